// File: rtl/i2c_init_sequencer_if.sv
// i2c_init_sequencer_if: command/handshake bundle between the init sequencer and an i2c_master
interface i2c_init_sequencer_if;
  logic       m_start;
  logic [6:0] m_address;
  logic       m_rw;
  logic [7:0] m_data;
  logic       m_busy;
  logic       m_ack;
  modport master (output m_start, m_address, m_rw, m_data, input m_busy, m_ack);
  modport slave  (input m_start, m_address, m_rw, m_data, output m_busy, m_ack);
endinterface

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a ROM of single-byte writes through an i2c_master,
// one transaction per entry, with NACK retry, inter-transaction gap and busy timeout
module i2c_init_sequencer #(
  parameter int         NUM_CMDS   = 8,
  parameter logic [6:0] DEV_ADDR   = 7'h3C,
  parameter int         RETRY_MAX  = 3,
  parameter int         GAP_CYCLES = 1000,
  parameter int         TIMEOUT    = 4095
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  output logic [7:0]                  cmd_idx,
  input  logic [7:0]                  cmd_data,
  i2c_init_sequencer_if.master        bus,
  output logic                        running,
  output logic                        done,
  output logic                        error,
  output logic [7:0]                  err_idx
);
  typedef enum logic [3:0] {IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, CHECK, GAP, DONE, FAIL} state_t;
  localparam logic [7:0]  LAST      = 8'(NUM_CMDS - 1);
  localparam logic [31:0] RETRY_LIM = 32'(RETRY_MAX);
  localparam logic [31:0] TO_LIM    = 32'(TIMEOUT);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam bit          NO_GAP    = GAP_CYCLES == 0;
  state_t      state, nxt;
  logic [7:0]  idx;
  logic [31:0] retry_cnt, gap_cnt, to_cnt;
  logic        ack_seen, last, retry_ok, timed_out;
  assign last      = idx == LAST;
  assign retry_ok  = retry_cnt < RETRY_LIM;
  assign timed_out = to_cnt == TO_LIM;
  assign cmd_idx       = idx;
  assign bus.m_address = DEV_ADDR;
  assign bus.m_rw      = 1'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = go ? FETCH : IDLE;
      FETCH:      nxt = ISSUE;
      ISSUE:      nxt = WAIT_HI;
      WAIT_HI:    nxt = bus.m_busy ? WAIT_LO : timed_out ? FAIL : WAIT_HI;
      WAIT_LO:    nxt = bus.m_busy ? WAIT_LO : CHECK;
      CHECK:      nxt = (ack_seen && last) ? DONE : (ack_seen || retry_ok) ? (NO_GAP ? FETCH : GAP) : FAIL;
      GAP:        nxt = gap_cnt == GAP_LAST ? FETCH : GAP;
      DONE, FAIL: nxt = go ? state : IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.m_start = state == ISSUE;
    running     = !(state inside {IDLE, DONE, FAIL});
  end
  // idx only advances on an ACK that is not the last entry, so it never wraps
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx        <= '0;
      retry_cnt  <= '0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      ack_seen   <= 1'b0;
      bus.m_data <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_idx    <= '0;
    end else begin
      if (state == IDLE && go) begin
        idx       <= '0;
        retry_cnt <= '0;
        done      <= 1'b0;
        error     <= 1'b0;
      end
      if (state == FETCH) bus.m_data <= cmd_data;
      if (state == ISSUE) begin
        ack_seen <= 1'b0;
        to_cnt   <= '0;
      end
      if (state == WAIT_HI && !bus.m_busy && !timed_out) to_cnt <= to_cnt + 1;
      if (state == WAIT_LO && bus.m_ack) ack_seen <= 1'b1;
      if (state == CHECK) begin
        gap_cnt <= '0;
        if (ack_seen) begin
          retry_cnt <= '0;
          if (!last) idx <= idx + 8'd1;
        end else if (retry_ok) retry_cnt <= retry_cnt + 1;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 1;
      if (state == CHECK && nxt == DONE) done <= 1'b1;
      if (state != FAIL && nxt == FAIL) begin
        error   <= 1'b1;
        err_idx <= idx;
      end
    end
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: directed scenarios against a cycle-level i2c_master model
// with per-entry NACK injection and a mode that never raises busy
module tb_i2c_init_sequencer;
  localparam int G = 8;
  localparam int T = 20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go = 1'b0;
  logic [7:0] cmd_idx, cmd_data, err_idx;
  logic running, done, error;
  logic [7:0] rom [3] = '{8'hAE, 8'hD5, 8'h80};
  i2c_init_sequencer_if bus();
  i2c_init_sequencer #(.NUM_CMDS(3), .DEV_ADDR(7'h3C), .RETRY_MAX(3), .GAP_CYCLES(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .go(go), .cmd_idx(cmd_idx), .cmd_data(cmd_data), .bus(bus),
    .running(running), .done(done), .error(error), .err_idx(err_idx));
  assign cmd_data = (cmd_idx < 8'd3) ? rom[cmd_idx[1:0]] : 8'h00;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0;
  int checks = 0;
  // master model state and transaction log
  bit no_busy = 0;
  int nack_idx = 255;
  int nack_left = 0;
  bit ack_val = 0;
  int mcnt = 0;
  int n_starts = 0;
  int bad_start = 0;
  int bad_addr = 0;
  int min_gap = 1 << 30;
  int fall_c = 0;
  bit have_fall = 0;
  logic [7:0] log_data [32];
  logic [7:0] log_idx [32];
  initial begin
    logic st;
    logic [7:0] ci, d;
    logic [6:0] a;
    logic rw;
    int now_c;
    bus.m_busy = 1'b0;
    bus.m_ack = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      st = bus.m_start; ci = cmd_idx; d = bus.m_data; a = bus.m_address; rw = bus.m_rw; now_c = cyc;
      if (!rst) begin
        bus.m_busy = 1'b0; bus.m_ack = 1'b0; mcnt = 0; n_starts = 0; have_fall = 0; min_gap = 1 << 30;
        bad_start = 0; bad_addr = 0;
      end else begin
        if (st === 1'b1 && bus.m_busy === 1'b1) bad_start++;
        #1;
        if (mcnt != 0) begin
          mcnt++;
          if (mcnt == 4) bus.m_ack = ack_val;
          if (mcnt == 5) bus.m_ack = 1'b0;
          if (mcnt == 7) begin bus.m_busy = 1'b0; mcnt = 0; fall_c = now_c; have_fall = 1; end
        end else if (st === 1'b1) begin
          if (n_starts < 32) begin log_data[n_starts] = d; log_idx[n_starts] = ci; end
          if (a !== 7'h3C || rw !== 1'b0) bad_addr++;
          if (have_fall && now_c - fall_c < min_gap) min_gap = now_c - fall_c;
          n_starts++;
          if (!no_busy) begin
            ack_val = !(int'(ci) == nack_idx && nack_left != 0);
            if (!ack_val && nack_left != 255) nack_left--;
            bus.m_busy = 1'b1;
            mcnt = 1;
          end
        end
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    go = 0; rst = 0; no_busy = 0; nack_idx = 255; nack_left = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask
  task automatic wait_end(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = done || error;
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0h want=0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h want=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0h want=0", error); end
    checks++; if (bus.m_start !== 1'b0) begin errors++; $display("FAIL reset_m_start got=%0h want=0", bus.m_start); end
    checks++; if (bus.m_address !== 7'h3C) begin errors++; $display("FAIL reset_m_address got=%0h want=3c", bus.m_address); end
    checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got=%0h want=0", bus.m_data); end
    checks++; if (cmd_idx !== 8'h00 || err_idx !== 8'h00) begin errors++; $display("FAIL reset_idx got=%0h/%0h want=0/0", cmd_idx, err_idx); end
    rst = 1;
  endtask
  task automatic test_sequence();
    bit ok;
    @(negedge clk); go = 1;
    @(negedge clk);
    checks++; if (bus.m_start !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL seq_fetch start/running got=%0h/%0h want=0/1", bus.m_start, running); end
    @(negedge clk);
    checks++; if (bus.m_start !== 1'b1 || bus.m_data !== 8'hAE) begin errors++; $display("FAIL seq_latency start/data got=%0h/%0h want=1/ae", bus.m_start, bus.m_data); end
    wait_end(ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_end_timeout got=0 want=1"); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL seq_status done/error got=%0h/%0h want=1/0", done, error); end
    checks++; if (n_starts !== 3) begin errors++; $display("FAIL seq_starts got=%0d want=3", n_starts); end
    checks++; if ({log_data[0], log_data[1], log_data[2]} !== 24'hAED580) begin errors++; $display("FAIL seq_data got=%h%h%h want=aed580", log_data[0], log_data[1], log_data[2]); end
    checks++; if ({log_idx[0], log_idx[1], log_idx[2]} !== 24'h000102) begin errors++; $display("FAIL seq_idx got=%h%h%h want=000102", log_idx[0], log_idx[1], log_idx[2]); end
    checks++; if (min_gap !== G + 4) begin errors++; $display("FAIL seq_gap got=%0d want=%0d", min_gap, G + 4); end
    checks++; if (bad_start !== 0 || bad_addr !== 0) begin errors++; $display("FAIL seq_bus_rules got=%0d/%0d want=0/0", bad_start, bad_addr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL seq_running got=%0h want=0", running); end
  endtask
  task automatic test_retry();
    bit ok;
    do_reset();
    nack_idx = 1; nack_left = 1;
    @(negedge clk); go = 1;
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL retry_status ok/done/error got=%0h/%0h/%0h want=1/1/0", ok, done, error); end
    checks++; if (n_starts !== 4) begin errors++; $display("FAIL retry_starts got=%0d want=4", n_starts); end
    checks++; if ({log_data[0], log_data[1], log_data[2], log_data[3]} !== 32'hAED5D580) begin errors++; $display("FAIL retry_data got=%h%h%h%h want=aed5d580", log_data[0], log_data[1], log_data[2], log_data[3]); end
    checks++; if (dut.retry_cnt !== 32'd0) begin errors++; $display("FAIL retry_cnt_cleared got=%0d want=0", dut.retry_cnt); end
  endtask
  task automatic test_retry_exhausted();
    bit ok;
    do_reset();
    nack_idx = 2; nack_left = 255;
    @(negedge clk); go = 1;
    wait_end(ok);
    checks++; if (!ok || error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL exhaust_status ok/error/done got=%0h/%0h/%0h want=1/1/0", ok, error, done); end
    checks++; if (err_idx !== 8'd2) begin errors++; $display("FAIL exhaust_err_idx got=%0d want=2", err_idx); end
    checks++; if (n_starts !== 6) begin errors++; $display("FAIL exhaust_starts got=%0d want=6", n_starts); end
    checks++; if (log_idx[2] !== 8'd2 || log_idx[5] !== 8'd2 || log_data[5] !== 8'h80) begin errors++; $display("FAIL exhaust_last_attempt idx/data got=%0d/%0d/%h want=2/2/80", log_idx[2], log_idx[5], log_data[5]); end
    repeat (5) @(negedge clk);
    checks++; if (error !== 1'b1 || running !== 1'b0 || n_starts !== 6) begin errors++; $display("FAIL exhaust_hold error/running/starts got=%0h/%0h/%0d want=1/0/6", error, running, n_starts); end
  endtask
  task automatic test_timeout();
    do_reset();
    no_busy = 1;
    @(negedge clk); go = 1;
    repeat (2) @(negedge clk);
    checks++; if (bus.m_start !== 1'b1) begin errors++; $display("FAIL to_issue got=%0h want=1", bus.m_start); end
    repeat (T + 1) @(negedge clk);
    checks++; if (error !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL to_early error/running got=%0h/%0h want=0/1", error, running); end
    @(negedge clk);
    checks++; if (error !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL to_fire error/running got=%0h/%0h want=1/0", error, running); end
    checks++; if (err_idx !== 8'd0 || done !== 1'b0) begin errors++; $display("FAIL to_err_idx/done got=%0d/%0h want=0/0", err_idx, done); end
    checks++; if (n_starts !== 1) begin errors++; $display("FAIL to_starts got=%0d want=1", n_starts); end
  endtask
  task automatic test_reset_midrun();
    bit ok;
    do_reset();
    @(negedge clk); go = 1;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); ok = n_starts == 2; end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_entry1 got=%0d want=2", n_starts); end
    @(posedge clk); #2;
    checks++; if (running !== 1'b1 || bus.m_busy !== 1'b1 || bus.m_data !== 8'hD5) begin errors++; $display("FAIL mid_in_wait_lo running/busy/data got=%0h/%0h/%h want=1/1/d5", running, bus.m_busy, bus.m_data); end
    rst = 0;
    #1;
    checks++; if (running !== 1'b0 || bus.m_start !== 1'b0 || bus.m_data !== 8'h00) begin errors++; $display("FAIL mid_async running/start/data got=%0h/%0h/%h want=0/0/00", running, bus.m_start, bus.m_data); end
    checks++; if (cmd_idx !== 8'd0 || done !== 1'b0 || error !== 1'b0 || bus.m_address !== 7'h3C) begin errors++; $display("FAIL mid_async idx/done/error/addr got=%0h/%0h/%0h/%h want=0/0/0/3c", cmd_idx, done, error, bus.m_address); end
    go = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); go = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.m_start !== 1'b1 || cmd_idx !== 8'd0 || bus.m_data !== 8'hAE) begin errors++; $display("FAIL mid_restart start/idx/data got=%0h/%0d/%h want=1/0/ae", bus.m_start, cmd_idx, bus.m_data); end
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1 || n_starts !== 3) begin errors++; $display("FAIL mid_rerun ok/done/starts got=%0h/%0h/%0d want=1/1/3", ok, done, n_starts); end
  endtask
  task automatic test_back_to_back();
    bit ok;
    do_reset();
    @(negedge clk); go = 1;
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL b2b_first ok/done got=%0h/%0h want=1/1", ok, done); end
    repeat (40) @(negedge clk);
    checks++; if (n_starts !== 3 || done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL b2b_hold starts/done/running got=%0d/%0h/%0h want=3/1/0", n_starts, done, running); end
    go = 0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL b2b_idle_sticky done/running got=%0h/%0h want=1/0", done, running); end
    go = 1;
    @(negedge clk);
    checks++; if (done !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL b2b_clear done/running got=%0h/%0h want=0/1", done, running); end
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1 || n_starts !== 6) begin errors++; $display("FAIL b2b_second ok/done/starts got=%0h/%0h/%0d want=1/1/6", ok, done, n_starts); end
    checks++; if ({log_data[3], log_data[4], log_data[5]} !== 24'hAED580) begin errors++; $display("FAIL b2b_data got=%h%h%h want=aed580", log_data[3], log_data[4], log_data[5]); end
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_retry();
    test_retry_exhausted();
    test_timeout();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
